// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue: buffered decode stage between fetch and register-read/issue.
//
// Contents of this file:
//   decoder_pkg  - decoded record type and opcode encoding
//   decoder      - combinational instruction decoder
//   decode_queue - DEPTH-entry {pc, instr} FIFO, decoder on the head entry,
//                  registered decoded output with ready/valid handshake,
//                  branch-target adder, flush, and optional halt on an
//                  undefined instruction.
//
// Instruction encoding understood by the decoder:
//   [3:0]   opcode  (0x0 = ALU class, 0xF = branch-and-link)
//   ALU:    [5:4] funct (00 reg-reg, 01 reg-imm, others undefined)
//           [10:6] rd, [15:11] rs1, [20:16] rs2 (reg-reg), [31:16] imm (reg-imm)
//   BAL:    [31:4] signed byte offset; writes link register r31
//
// decode_queue ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   fetch offers {in_pc, in_instr}
//   in_ready    out  queue accepts an entry this cycle
//   in_pc       in   PC of in_instr (PC_W bits)
//   in_instr    in   raw 32-bit instruction word
//   out_valid   out  out_dec / out_pc / out_target hold a valid record
//   out_ready   in   downstream consumes the output this cycle
//   out_dec     out  decoded record (decoded_t)
//   out_pc      out  PC of the output instruction
//   out_target  out  out_pc + sign-extended branch offset, mod 2^PC_W
//   flush       in   discard all buffered and output state
//   halted      out  an undefined instruction issued (HALT_ON_UNDEF=1)
//   count       out  FIFO occupancy, not counting the output register
// ---------------------------------------------------------------------------

package decoder_pkg;

    localparam int BOFF_W = 28;

    localparam logic [3:0] OP_ALU = 4'h0;
    localparam logic [3:0] OP_BAL = 4'hF;

    localparam logic [1:0] FN_RR = 2'b00;
    localparam logic [1:0] FN_RI = 2'b01;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [15:0]       imm;
        logic              op2_imm;
        logic              w_rd;
        logic              branch;
        logic              link;
        logic [BOFF_W-1:0] branch_off;
        logic              undefined;
    } decoded_t;

endpackage

// Purely combinational decoder.
//   i_instr  in   raw instruction word
//   o_dec    out  decoded record
module decoder
    import decoder_pkg::*;
(
    input  logic [31:0] i_instr,
    output decoded_t    o_dec
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a field unassigned, which would otherwise infer a latch.
        o_dec = '0;
        unique case (i_instr[3:0])
            OP_ALU: begin
                o_dec.rd  = i_instr[10:6];
                o_dec.rs1 = i_instr[15:11];
                unique case (i_instr[5:4])
                    FN_RR: begin
                        o_dec.rs2  = i_instr[20:16];
                        o_dec.w_rd = 1'b1;
                    end
                    FN_RI: begin
                        o_dec.imm     = i_instr[31:16];
                        o_dec.op2_imm = 1'b1;
                        o_dec.w_rd    = 1'b1;
                    end
                    default: begin
                        o_dec           = '0;
                        o_dec.undefined = 1'b1;
                    end
                endcase
            end
            OP_BAL: begin
                o_dec.branch     = 1'b1;
                o_dec.link       = 1'b1;
                o_dec.rd         = LINK_REG;
                o_dec.w_rd       = 1'b1;
                o_dec.branch_off = i_instr[31:4];
            end
            default: begin
                o_dec.undefined = 1'b1;
            end
        endcase
    end

endmodule

module decode_queue
    import decoder_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int PC_W          = 32,
    parameter bit HALT_ON_UNDEF = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output decoded_t                   out_dec,
    output logic [PC_W-1:0]            out_pc,
    output logic [PC_W-1:0]            out_target,
    input  logic                       flush,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [PC_W-1:0]   r_mem_pc    [DEPTH];
    logic [31:0]       r_mem_instr [DEPTH];

    decoded_t          r_out_dec;
    logic [PC_W-1:0]   r_out_pc;
    logic [PC_W-1:0]   r_out_target;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_halt_now;
    decoded_t          w_head_dec;
    logic [PC_W-1:0]   w_head_pc;
    logic [PC_W-1:0]   w_off_ext;
    logic [PC_W-1:0]   w_head_target;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // in_ready depends only on rst and registered state, never on out_ready.
    assign in_ready = !rst && (r_state != S_HALT) && !w_full;

    // An entry offered in a flush cycle is dropped.
    assign w_push = in_valid && in_ready && !flush;

    // Handshake on an undefined record parks the stage instead of popping.
    assign w_halt_now = HALT_ON_UNDEF && (r_state == S_VALID) && out_ready
                        && r_out_dec.undefined;

    // Decode the FIFO head; the result is only captured on a pop.
    assign w_head_pc = r_mem_pc[r_rd_ptr];

    decoder u_decoder (
        .i_instr (r_mem_instr[r_rd_ptr]),
        .o_dec   (w_head_dec)
    );

    // Sign-extend the offset to PC width; the add wraps silently.
    assign w_off_ext     = PC_W'($signed(w_head_dec.branch_off));
    assign w_head_target = w_head_pc + w_off_ext;

    // ---------------------------------------------------------------------
    // Output state machine: next state and pop decision.
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = S_VALID;
                    end
                end
                S_VALID: begin
                    if (out_ready) begin
                        if (w_halt_now) begin
                            w_next_state = S_HALT;
                        end else if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_next_state = S_VALID;
                        end else begin
                            w_next_state = S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    w_next_state = S_HALT;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO pointers and occupancy.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers alone
    // decide which slots are meaningful, so clearing it would be wasted logic.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= in_pc;
            r_mem_instr[r_wr_ptr] <= in_instr;
        end
    end

    // ---------------------------------------------------------------------
    // Output register: loads only on pop, so it holds while stalled.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_dec    <= '0;
            r_out_pc     <= '0;
            r_out_target <= '0;
        end else if (w_pop) begin
            r_out_dec    <= w_head_dec;
            r_out_pc     <= w_head_pc;
            r_out_target <= w_head_target;
        end
    end

    assign out_valid  = (r_state == S_VALID);
    assign halted     = (r_state == S_HALT);
    assign out_dec    = r_out_dec;
    assign out_pc     = r_out_pc;
    assign out_target = r_out_target;
    assign count      = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue: directed self-checking bench for decode_queue
// (DEPTH=4, PC_W=32, HALT_ON_UNDEF=1). Inputs change 1 ns after the rising
// edge; outputs are checked at the same point, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_decode_queue;
    import decoder_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic                       clk;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [PC_W-1:0]            in_pc;
    logic [31:0]                in_instr;
    logic                       out_valid;
    logic                       out_ready;
    decoded_t                   out_dec;
    logic [PC_W-1:0]            out_pc;
    logic [PC_W-1:0]            out_target;
    logic                       flush;
    logic                       halted;
    logic [$clog2(DEPTH+1)-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    decode_queue #(
        .DEPTH         (DEPTH),
        .PC_W          (PC_W),
        .HALT_ON_UNDEF (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dec    (out_dec),
        .out_pc     (out_pc),
        .out_target (out_target),
        .flush      (flush),
        .halted     (halted),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ALU reg-imm word: rd=3, rs1=2, imm=v
    function automatic logic [31:0] alu_ri(input int v);
        return {16'(v), 16'h10D0};
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // ---------------- reset ----------------
        tick();
        check("rst_in_ready", in_ready, 0);
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_halted", halted, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_target", out_target, 0);
        check("rst_out_dec", 64'(out_dec), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // ---------------- basic ALU decode ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h100;
        in_instr  = 32'h000510D0;
        tick();
        check("alu_count_after_push", count, 1);
        check("alu_no_bypass", out_valid, 0);
        in_valid = 1'b0;
        tick();
        check("alu_out_valid", out_valid, 1);
        check("alu_rd", out_dec.rd, 3);
        check("alu_rs1", out_dec.rs1, 2);
        check("alu_imm", out_dec.imm, 5);
        check("alu_op2_imm", out_dec.op2_imm, 1);
        check("alu_w_rd", out_dec.w_rd, 1);
        check("alu_branch", out_dec.branch, 0);
        check("alu_out_pc", out_pc, 32'h100);
        check("alu_count", count, 0);
        tick();
        check("alu_drain_valid", out_valid, 0);

        // ---------------- branch targets ----------------
        in_valid = 1'b1;
        in_pc    = 32'h200;
        in_instr = 32'h0000010F;
        tick();
        in_pc    = 32'hFFFFFFF8;
        tick();
        in_valid = 1'b0;
        check("br_valid", out_valid, 1);
        check("br_branch", out_dec.branch, 1);
        check("br_link", out_dec.link, 1);
        check("br_rd", out_dec.rd, 31);
        check("br_w_rd", out_dec.w_rd, 1);
        check("br_pc", out_pc, 32'h200);
        check("br_target", out_target, 32'h210);
        tick();
        check("br_wrap_pc", out_pc, 32'hFFFFFFF8);
        check("br_wrap_target", out_target, 32'h00000008);
        tick();
        check("br_drain_valid", out_valid, 0);

        // ---------------- backpressure / full ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h300 + 32'(4 * i);
            in_instr = alu_ri(i);
            #1;
            check($sformatf("full_in_ready_%0d", i), in_ready, (i < 5) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_head_pc", out_pc, 32'h300);
        tick();
        tick();
        check("stall_pc", out_pc, 32'h300);
        check("stall_imm", out_dec.imm, 0);
        check("stall_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("drain_pc_%0d", k), out_pc, 32'h300 + 32'(4 * k));
            check($sformatf("drain_imm_%0d", k), out_dec.imm, 64'(k));
            check($sformatf("drain_count_%0d", k), count, 64'(4 - k));
        end
        tick();
        check("drain_idle", out_valid, 0);

        // ---------------- halt on undefined ----------------
        in_valid = 1'b1;
        in_pc    = 32'h400;
        in_instr = 32'h00000020;
        tick();
        in_pc    = 32'h404;
        in_instr = alu_ri(1);
        tick();
        check("undef_valid", out_valid, 1);
        check("undef_flag", out_dec.undefined, 1);
        check("undef_pc", out_pc, 32'h400);
        in_pc    = 32'h408;
        in_instr = alu_ri(2);
        tick();
        in_valid = 1'b0;
        check("halt_halted", halted, 1);
        check("halt_out_valid", out_valid, 0);
        check("halt_in_ready", in_ready, 0);
        check("halt_count", count, 2);
        tick();
        check("halt_hold_count", count, 2);
        check("halt_hold", halted, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_halted", halted, 0);
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_pc    = 32'h500;
        in_instr = alu_ri(7);
        tick();
        in_valid = 1'b0;
        tick();
        check("after_flush_valid", out_valid, 1);
        check("after_flush_imm", out_dec.imm, 7);
        check("after_flush_pc", out_pc, 32'h500);
        check("after_flush_undef", out_dec.undefined, 0);
        tick();

        // ---------------- simultaneous push/pop at count=2 ----------------
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1;
            in_pc    = 32'h600 + 32'(4 * n);
            in_instr = alu_ri(n);
            tick();
        end
        check("pp_setup_count", count, 2);
        check("pp_setup_pc", out_pc, 32'h600);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h600 + 32'(4 * (3 + k));
            in_instr = alu_ri(3 + k);
            tick();
            check($sformatf("pp_count_%0d", k), count, 2);
            check($sformatf("pp_pc_%0d", k), out_pc, 32'h600 + 32'(4 * (k + 1)));
            check($sformatf("pp_imm_%0d", k), out_dec.imm, 64'(k + 1));
        end
        in_valid = 1'b0;
        tick();
        check("pp_tail_pc_11", out_pc, 32'h600 + 32'(4 * 11));
        tick();
        check("pp_tail_pc_12", out_pc, 32'h600 + 32'(4 * 12));
        check("pp_tail_count", count, 0);
        tick();
        check("pp_idle", out_valid, 0);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1;
            in_pc    = 32'h700 + 32'(4 * n);
            in_instr = 32'h0000010F;
            tick();
        end
        in_valid = 1'b0;
        check("mid_count", count, 3);
        check("mid_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_pc", out_pc, 0);
        check("mid_rst_target", out_target, 0);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_dec", 64'(out_dec), 0);

        // ---------------- flush drops concurrent in_valid ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h800;
        in_instr  = alu_ri(9);
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_drop_count", count, 0);
        check("flush_drop_valid0", out_valid, 0);
        tick();
        check("flush_drop_valid1", out_valid, 0);
        check("flush_drop_count1", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered decode stage between fetch and register-read/issue.
- Accepts {pc, instr} pairs from fetch into a DEPTH-entry FIFO, decodes the head entry through the existing combinational `decoder`, and presents one registered decoded_t record per cycle with a ready/valid handshake.
- Adds what the bare decoder lacks: buffering, backpressure, branch-target computation, flush, and a halt-on-undefined mode.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PC_W, 32, PC width; instr is fixed at 32 bits.
- HALT_ON_UNDEF, 1, if 1, intake stops after an undefined instruction issues, until flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  queue can accept an entry.
- in_pc  in  PC_W  PC of in_instr.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  out_dec/out_pc/out_target are valid.
- out_ready  in  1  downstream consumes the output this cycle.
- out_dec  out  decoded_t  decoded record (decoder_pkg).
- out_pc  out  PC_W  PC of the output instruction.
- out_target  out  PC_W  out_pc + sign-extended out_dec.branch_off, truncated to PC_W.
- flush  in  1  discard all buffered and output state.
- halted  out  1  undefined instruction issued, HALT_ON_UNDEF=1.
- count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register.

Behaviour:
- Reset (synchronous, active-high): wr/rd pointers 0; count 0; out_valid 0; out_dec all-zero; out_pc 0; out_target 0; halted 0; in_ready 0 during the reset cycle.
- Push: in_valid && in_ready. Pop: FIFO non-empty && (!out_valid || out_ready).
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- in_ready = !rst && !halted && (count < DEPTH). No combinational path from out_ready to in_ready.
- Output register loads on pop, from the FIFO head via the decoder. out_dec/out_pc/out_target stay stable while out_valid && !out_ready.
- If out_ready is high and the FIFO is empty, out_valid drops to 0 next cycle.
- Latency: an entry pushed into an empty queue with out_valid=0 appears on out_valid two cycles later (push edge, then pop edge). No same-cycle bypass.
- Throughput: 1/cycle sustained with out_ready held high.
- Output state machine (IDLE / VALID / HALT):
  - IDLE→VALID on pop.
  - VALID→VALID on pop with out_ready.
  - VALID→IDLE on out_ready with FIFO empty.
  - VALID→HALT when an entry with out_dec.undefined=1 is accepted (out_valid && out_ready) and HALT_ON_UNDEF=1. halted=1 in HALT.
  - In HALT: in_ready=0, no further pops, out_valid=0. FIFO contents are retained.
  - Any state→IDLE on flush.
- Flush (synchronous): pointers and count to 0, out_valid 0, halted 0. An in_valid entry in the flush cycle is dropped.
- Flush has priority over push, pop and the transition to HALT. rst has priority over flush.
- With HALT_ON_UNDEF=0, undefined instructions pass through with out_dec.undefined=1 and no halt.
- Arithmetic: out_target computed at the pop edge, mod 2^PC_W. Wrap-around is not flagged.
- Full: in_valid with count==DEPTH is ignored. The fetch side must hold its entry (standard valid/ready; in_valid may not drop without a handshake).

Test Plan:
- Basic ALU decode: reset, push {pc=0x100, instr=0x000510D0}, out_ready=1 → out_valid rises 2 cycles later; out_dec.rd=3, rs1=2, imm=5, op2_imm=1, w_rd=1; out_pc=0x100.
- Branch target: push {pc=0x200, instr=0x0000010F} → out_dec.branch=1, link=1, rd=31, w_rd=1, out_target=0x210. Also pc=0xFFFFFFF8, offset 16 → out_target=0x00000008.
- Backpressure/full: out_ready=0, push 6 entries with DEPTH=4 → 5 accepted (4 FIFO + 1 output), in_ready=0, count=4. Raise out_ready → entries emerge in push order, one per cycle, outputs stable while stalled.
- Halt on undefined: push 0x00000020 followed by valid entries, out_ready=1 → after the handshake on the undefined entry, halted=1, in_ready=0, out_valid=0. Flush → halted=0, count=0; next push decodes normally.
- Simultaneous push/pop at count=2 for 10 cycles → count stays 2, no drop or duplicate (scoreboard compare).
- Reset mid-operation: count=3 and out_valid=1, assert rst one cycle → all outputs at reset values next cycle. Flush asserted together with in_valid → that entry is dropped.
